tt_sweep_ctrl: RTL and testbench

Sequencer that exercises a 3-input, 1-output combinational logic circuit from the tested-circuit library, for example the 0x47 mux variant. It drives every input combination in a fixed order, waits a programmable settle time, and samples the circuit output. It then compares the 8 captured samples against an expected truth-table word and reports pass/fail plus a per-combination mismatch mask. It sits between a host or testbench controller and one circuit instance.

---
 rtl/tt_sweep_ctrl.sv | 123 ++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: drives a 3-input circuit through all 8 combinations and
// checks the sampled truth table. Optional TT_SWEEP_CONT_EN adds `cont`.
module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef TT_SWEEP_CONT_EN
  input  logic       cont,
`endif
  input  logic [7:0] expected,
  input  logic       dut_out,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  output logic       busy,
  output logic       done,
  output logic [7:0] observed,
  output logic [7:0] mismatch,
  output logic       pass
);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  state_t     state;
  state_t     state_d;
  logic [2:0] idx;
  logic [7:0] cnt;
  logic [7:0] exp_q;
  logic [7:0] obs_smp;
  logic       load;
  logic       sample;
  logic       last;
  logic       cont_go;

`ifdef TT_SWEEP_CONT_EN
  assign cont_go = (state == DONE) && cont;
`else
  assign cont_go = 1'b0;
`endif

  assign load   = ((state == IDLE) && start) || cont_go;
  assign sample = (state == DRIVE) && !abort
                  && (cnt == SETTLE);
  assign last   = sample && (idx == 3'd7);

  // combination i lands at bit 7-i, so 000 is the MSB
  always_comb begin
    obs_smp = observed;
    if (sample) obs_smp[3'd7 - idx] = dut_out;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE: begin
        if (start) state_d = DRIVE;
      end
      DRIVE: begin
        if (abort) state_d = IDLE;
        else if (last) state_d = DONE;
      end
      DONE: begin
        state_d = cont_go ? DRIVE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 3'd0;
      cnt      <= 8'd0;
      exp_q    <= 8'd0;
      observed <= 8'd0;
      mismatch <= 8'd0;
      pass     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        exp_q    <= expected;
        idx      <= 3'd0;
        cnt      <= 8'd0;
        observed <= 8'd0;
        mismatch <= 8'd0;
        pass     <= 1'b0;
        busy     <= 1'b1;
      end else if (state == DRIVE) begin
        if (abort) begin
          busy <= 1'b0;
          idx  <= 3'd0;
          cnt  <= 8'd0;
        end else if (sample) begin
          cnt      <= 8'd0;
          observed <= obs_smp;
          if (last) begin
            busy     <= 1'b0;
            mismatch <= obs_smp ^ exp_q;
            pass     <= (obs_smp == exp_q);
          end else begin
            idx <= idx + 3'd1;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  assign done = (state == DONE);
  assign {dut_in1, dut_in2, dut_in3} = idx;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb_tt_sweep_ctrl: directed sweeps against a behavioural circuit model,
// results checked through a scoreboard queue.
module tb_tt_sweep_ctrl;

  localparam int S = 2;
  localparam int W = S + 1;
  localparam int T = 8 * W;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       dut_out;
`ifdef TT_SWEEP_CONT_EN
  logic       cont = 1'b0;
`endif
  logic       dut_in1;
  logic       dut_in2;
  logic       dut_in3;
  logic       busy;
  logic       done;
  logic [7:0] observed;
  logic [7:0] mismatch;
  logic       pass;

  logic [7:0] tt = 8'h47;
  logic       stuck = 1'b0;
  logic [2:0] din;

  int checks = 0;
  int failures = 0;
  int dn = 0;

  typedef struct packed {
    logic [7:0] obs;
    logic [7:0] mm;
    logic       ps;
  } res_t;

  res_t sb[$];

  tt_sweep_ctrl #(.SETTLE_CYCLES(S)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
`ifdef TT_SWEEP_CONT_EN
    .cont     (cont),
`endif
    .expected (expected),
    .dut_out  (dut_out),
    .dut_in1  (dut_in1),
    .dut_in2  (dut_in2),
    .dut_in3  (dut_in3),
    .busy     (busy),
    .done     (done),
    .observed (observed),
    .mismatch (mismatch),
    .pass     (pass)
  );

  always #5 clk = ~clk;

  assign din = {dut_in1, dut_in2, dut_in3};
  assign dut_out = stuck ? 1'b0 : tt[3'd7 - din];

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic reset_state(input string tag);
    chk({tag, "_in"}, 8'(din), 8'h00);
    chk({tag, "_busy"}, 8'(busy), 8'h00);
    chk({tag, "_done"}, 8'(done), 8'h00);
    chk({tag, "_obs"}, observed, 8'h00);
    chk({tag, "_mm"}, mismatch, 8'h00);
    chk({tag, "_pass"}, 8'(pass), 8'h00);
  endtask

  // abort_c < 0: full sweep; poke: extra starts mid-sweep
  task automatic sweep(input logic [7:0] e,
                       input int abort_c,
                       input bit poke);
    res_t r;
    int n;
    int cnt_done;
    logic [7:0] ff;
    logic [7:0] part;
    cnt_done = 0;
    ff = 8'hFF;
    n = (abort_c < 0) ? 0 : abort_c / W;
    part = (stuck ? 8'h00 : tt) & ~(ff >> n);
    @(negedge clk);
    expected = e;
    start = 1'b1;
    if (abort_c < 0) begin
      r.obs = stuck ? 8'h00 : tt;
      r.mm = r.obs ^ e;
      r.ps = (r.obs == e);
      sb.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= T + 6; c++) begin
      if (abort_c >= 0 && c > abort_c) begin
        chk("abort_busy", 8'(busy), 8'h00);
        chk("abort_in", 8'(din), 8'h00);
        if (c == abort_c + 1) begin
          chk("abort_obs", observed, part);
          chk("abort_pass", 8'(pass), 8'h00);
        end
      end else if (c < T + 2) begin
        chk("in_order", 8'(din),
            (c < T) ? 8'(c / W) : 8'h07);
        chk("busy", 8'(busy), 8'(c < T));
        chk("done", 8'(done), 8'(c == T));
        if (c == 0) begin
          chk("clr_obs", observed, 8'h00);
          chk("clr_pass", 8'(pass), 8'h00);
        end
        if (c == T && sb.size() > 0) begin
          r = sb.pop_front();
          chk("observed", observed, r.obs);
          chk("mismatch", mismatch, r.mm);
          chk("pass", 8'(pass), 8'(r.ps));
        end
      end
      if (done) cnt_done++;
      start = 1'b0;
      abort = 1'b0;
      if (poke && (c == 4 || c == 9)) begin
        start = 1'b1;
        expected = ~e;
      end
      if (c == abort_c) abort = 1'b1;
      @(negedge clk);
    end
    chk("done_count", 8'(cnt_done),
        (abort_c < 0) ? 8'h01 : 8'h00);
    chk("sb_empty", 8'(sb.size()), 8'h00);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_state("rst");
    rst_n = 1'b1;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    reset_state("idle_abort");

    sweep(8'h47, -1, 1'b0);

    stuck = 1'b1;
    sweep(8'h47, -1, 1'b0);
    stuck = 1'b0;

    tt = 8'hA5;
    sweep(8'h47, -1, 1'b0);
    tt = 8'h47;

    sweep(8'h47, -1, 1'b1);

    sweep(8'h47, 12, 1'b0);

    @(negedge clk);
    expected = 8'h47;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_state("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    sweep(8'h47, -1, 1'b0);

`ifdef TT_SWEEP_CONT_EN
    cont = 1'b1;
    dn = 0;
    @(negedge clk);
    expected = 8'h47;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c <= 150; c++) begin
      if (done) begin
        chk("cont_done_at", 8'(c),
            8'(T + dn * (T + 1)));
        dn++;
      end
      abort = (c == 3 * (T + 1) + 10);
      @(negedge clk);
    end
    cont = 1'b0;
    chk("cont_done_n", 8'(dn), 8'h03);
    chk("cont_busy", 8'(busy), 8'h00);
    chk("cont_in", 8'(din), 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
